// File: rtl/l2cache_plru_tree.sv
// Tree-PLRU victim selector for the L2: WAY-1 tree bits per set, invalid-way priority,
// registered victim with same-cycle update forwarding. Way locking enabled by L2_PLRU_LOCK_EN.
module l2cache_plru_tree #(
   parameter int SET_W = 4,
   parameter int WAY   = 4,
   parameter int WAY_W = 2
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             lkp_valid,
   input  logic [SET_W-1:0] lkp_set,
   input  logic [WAY-1:0]   lkp_vmask,
`ifdef L2_PLRU_LOCK_EN
   input  logic [WAY-1:0]   lkp_lock,
`endif
   input  logic             upd_valid,
   input  logic [SET_W-1:0] upd_set,
   input  logic [WAY_W-1:0] upd_way,
   output logic             vic_valid,
   output logic [WAY_W-1:0] vic_way,
   output logic             vic_fail
);

   localparam int SETS = 1 << SET_W;

   // Handshake: lkp_valid is sampled at a rising edge; vic_valid pulses for exactly the next
   // cycle with vic_way/vic_fail. No backpressure, so a new lookup may be issued every cycle.

   logic [WAY-2:0]   r_tree [SETS];
   logic             r_vic_valid;
   logic [WAY_W-1:0] r_vic_way;

   logic [WAY-1:0]   w_lock;
   logic             w_fwd_hit;
   logic [WAY-2:0]   w_cur_tree;
   logic [WAY-2:0]   w_sel_tree;
   logic [WAY-1:0]   w_elig_inv;
   logic             w_inv_found;
   logic [WAY_W-1:0] w_inv_way;
   logic [WAY_W-1:0] w_walk_way;
   logic             w_all_locked;
   logic [WAY_W-1:0] w_next_way;

   // Every node on the path to w is made to point at the other subtree.
   function automatic logic [WAY-2:0] f_update(input logic [WAY-2:0] t,
                                               input logic [WAY_W-1:0] w);
      logic [WAY-2:0] r;
      logic           b;
      int             node;
      r    = t;
      node = 0;
      for (int l = 0; l < WAY_W; l++) begin
         b       = w[WAY_W-1-l];
         r[node] = ~b;
         node    = 2 * node + 1 + int'(b);
      end
      return r;
   endfunction

   // Walk from the root; a subtree whose leaves are all locked is skipped for its sibling.
   function automatic logic [WAY_W-1:0] f_walk(input logic [WAY-2:0] t,
                                               input logic [WAY-1:0] lock);
      logic [WAY_W-1:0] path;
      logic             dir;
      logic             all_lk;
      int               node;
      int               sh;
      path = '0;
      node = 0;
      for (int l = 0; l < WAY_W; l++) begin
         dir               = t[node];
         path[WAY_W-1-l]   = dir;
         sh                = WAY_W - 1 - l;
         all_lk            = 1'b1;
         for (int w = 0; w < WAY; w++) begin
            if (((w >> sh) == (int'(path) >> sh)) && !lock[w]) all_lk = 1'b0;
         end
         if (all_lk) begin
            dir             = ~dir;
            path[WAY_W-1-l] = dir;
         end
         node = 2 * node + 1 + int'(dir);
      end
      return path;
   endfunction

`ifdef L2_PLRU_LOCK_EN
   assign w_lock = lkp_lock;
`else
   assign w_lock = '0;
`endif

   assign w_fwd_hit    = upd_valid && (upd_set == lkp_set);
   assign w_cur_tree   = r_tree[lkp_set];
   assign w_sel_tree   = w_fwd_hit ? f_update(w_cur_tree, upd_way) : w_cur_tree;
   assign w_elig_inv   = ~lkp_vmask & ~w_lock;
   assign w_all_locked = &w_lock;
   assign w_walk_way   = f_walk(w_sel_tree, w_lock);

   always_comb begin
      w_inv_found = 1'b0;
      w_inv_way   = '0;
      for (int w = WAY - 1; w >= 0; w--) begin
         if (w_elig_inv[w]) begin
            w_inv_found = 1'b1;
            w_inv_way   = WAY_W'(w);
         end
      end
   end

   always_comb begin
      w_next_way = w_walk_way;
      if (w_inv_found)       w_next_way = w_inv_way;
      else if (w_all_locked) w_next_way = '0;
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         for (int s = 0; s < SETS; s++) r_tree[s] <= '0;
         r_vic_valid <= 1'b0;
         r_vic_way   <= '0;
      end else begin
         if (upd_valid) r_tree[upd_set] <= f_update(r_tree[upd_set], upd_way);
         r_vic_valid <= lkp_valid;
         if (lkp_valid) r_vic_way <= w_next_way;
      end
   end

   assign vic_valid = r_vic_valid;
   assign vic_way   = r_vic_way;

`ifdef L2_PLRU_LOCK_EN
   logic r_vic_fail;
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn)          r_vic_fail <= 1'b0;
      else if (lkp_valid) r_vic_fail <= w_all_locked && !w_inv_found;
   end
   assign vic_fail = r_vic_fail;
`else
   assign vic_fail = 1'b0;
`endif

endmodule

// File: tb/tb_l2cache_plru_tree.sv
// Directed bench for l2cache_plru_tree: a 4-way/16-set instance and an 8-way/64-set instance.
module tb_l2cache_plru_tree;

   logic       clk;
   logic       rstn;

   logic       lkp_valid;
   logic [3:0] lkp_set;
   logic [3:0] lkp_vmask;
   logic [3:0] lkp_lock;
   logic       upd_valid;
   logic [3:0] upd_set;
   logic [1:0] upd_way;
   logic       vic_valid;
   logic [1:0] vic_way;
   logic       vic_fail;

   logic       l8_valid;
   logic [5:0] l8_set;
   logic [7:0] l8_vmask;
   logic [7:0] l8_lock;
   logic       u8_valid;
   logic [5:0] u8_set;
   logic [2:0] u8_way;
   logic       v8_valid;
   logic [2:0] v8_way;
   logic       v8_fail;

   int n_vec;
   int n_err;

   l2cache_plru_tree #(.SET_W(4), .WAY(4), .WAY_W(2)) u_dut4 (
      .clk       (clk),
      .rstn      (rstn),
      .lkp_valid (lkp_valid),
      .lkp_set   (lkp_set),
      .lkp_vmask (lkp_vmask),
`ifdef L2_PLRU_LOCK_EN
      .lkp_lock  (lkp_lock),
`endif
      .upd_valid (upd_valid),
      .upd_set   (upd_set),
      .upd_way   (upd_way),
      .vic_valid (vic_valid),
      .vic_way   (vic_way),
      .vic_fail  (vic_fail)
   );

   l2cache_plru_tree #(.SET_W(6), .WAY(8), .WAY_W(3)) u_dut8 (
      .clk       (clk),
      .rstn      (rstn),
      .lkp_valid (l8_valid),
      .lkp_set   (l8_set),
      .lkp_vmask (l8_vmask),
`ifdef L2_PLRU_LOCK_EN
      .lkp_lock  (l8_lock),
`endif
      .upd_valid (u8_valid),
      .upd_set   (u8_set),
      .upd_way   (u8_way),
      .vic_valid (v8_valid),
      .vic_way   (v8_way),
      .vic_fail  (v8_fail)
   );

   // clock / reset
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic idle_inputs();
      lkp_valid = 1'b0;
      lkp_set   = '0;
      lkp_vmask = '0;
      lkp_lock  = '0;
      upd_valid = 1'b0;
      upd_set   = '0;
      upd_way   = '0;
      l8_valid  = 1'b0;
      l8_set    = '0;
      l8_vmask  = '0;
      l8_lock   = '0;
      u8_valid  = 1'b0;
      u8_set    = '0;
      u8_way    = '0;
   endtask

   // One-cycle lookup on the 4-way instance, optionally with an update in the same cycle.
   task automatic lkp4(input logic [3:0] set, input logic [3:0] vmask, input logic [3:0] lock,
                       input logic uv, input logic [3:0] uset, input logic [1:0] uway);
      @(negedge clk);
      lkp_valid = 1'b1;
      lkp_set   = set;
      lkp_vmask = vmask;
      lkp_lock  = lock;
      upd_valid = uv;
      upd_set   = uset;
      upd_way   = uway;
      @(posedge clk);
      #1;
      lkp_valid = 1'b0;
      upd_valid = 1'b0;
      lkp_lock  = '0;
   endtask

   task automatic upd4(input logic [3:0] set, input logic [1:0] way);
      @(negedge clk);
      upd_valid = 1'b1;
      upd_set   = set;
      upd_way   = way;
      @(posedge clk);
      #1;
      upd_valid = 1'b0;
   endtask

   task automatic lkp8(input logic [5:0] set, input logic [7:0] vmask);
      @(negedge clk);
      l8_valid = 1'b1;
      l8_set   = set;
      l8_vmask = vmask;
      @(posedge clk);
      #1;
      l8_valid = 1'b0;
   endtask

   task automatic upd8(input logic [5:0] set, input logic [2:0] way);
      @(negedge clk);
      u8_valid = 1'b1;
      u8_set   = set;
      u8_way   = way;
      @(posedge clk);
      #1;
      u8_valid = 1'b0;
   endtask

   initial begin
      n_vec = 0;
      n_err = 0;
      idle_inputs();
      rstn = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_vic_valid", 32'(vic_valid), 32'd0);
      check("rst_vic_way", 32'(vic_way), 32'd0);
      check("rst_vic_fail", 32'(vic_fail), 32'd0);
      @(negedge clk);
      rstn = 1'b1;

      // T1: reset tree -> way 0
      lkp4(4'd3, 4'hF, 4'h0, 1'b0, 4'd0, 2'd0);
      check("t1_valid", 32'(vic_valid), 32'd1);
      check("t1_way", 32'(vic_way), 32'd0);
      check("t1_fail", 32'(vic_fail), 32'd0);
      @(posedge clk);
      #1;
      check("t1_pulse_end", 32'(vic_valid), 32'd0);

      // T2: ways 0,2,1 leave root=1,node1=0,node2=1 -> way 3; then way 3 -> way 0
      upd4(4'd3, 2'd0);
      upd4(4'd3, 2'd2);
      upd4(4'd3, 2'd1);
      lkp4(4'd3, 4'hF, 4'h0, 1'b0, 4'd0, 2'd0);
      check("t2_way3", 32'(vic_way), 32'd3);
      upd4(4'd3, 2'd3);
      lkp4(4'd3, 4'hF, 4'h0, 1'b0, 4'd0, 2'd0);
      check("t2_way0", 32'(vic_way), 32'd0);

      // T3: invalid priority overrides the tree
      lkp4(4'd3, 4'b1010, 4'h0, 1'b0, 4'd0, 2'd0);
      check("t3_inv_1010", 32'(vic_way), 32'd0);
      lkp4(4'd3, 4'b1011, 4'h0, 1'b0, 4'd0, 2'd0);
      check("t3_inv_1011", 32'(vic_way), 32'd2);
      upd4(4'd3, 2'd0);
      lkp4(4'd3, 4'b0111, 4'h0, 1'b0, 4'd0, 2'd0);
      check("t3_inv_0111", 32'(vic_way), 32'd3);
      lkp4(4'd3, 4'hF, 4'h0, 1'b0, 4'd0, 2'd0);
      check("t3_tree_after_w0", 32'(vic_way), 32'd2);

      // T4: same-cycle update forwards into the lookup of the same set only
      lkp4(4'd5, 4'hF, 4'h0, 1'b1, 4'd5, 2'd0);
      check("t4_fwd_valid", 32'(vic_valid), 32'd1);
      check("t4_fwd_way", 32'(vic_way), 32'd2);
      lkp4(4'd7, 4'hF, 4'h0, 1'b1, 4'd6, 2'd0);
      check("t4_nofwd_way", 32'(vic_way), 32'd0);
      lkp4(4'd6, 4'hF, 4'h0, 1'b0, 4'd0, 2'd0);
      check("t4_set6_committed", 32'(vic_way), 32'd2);
      lkp4(4'd5, 4'hF, 4'h0, 1'b0, 4'd0, 2'd0);
      check("t4_set5_committed", 32'(vic_way), 32'd2);
      // back-to-back lookups: second result replaces first on the very next cycle
      lkp4(4'd5, 4'hF, 4'h0, 1'b0, 4'd0, 2'd0);
      lkp4(4'd7, 4'hF, 4'h0, 1'b0, 4'd0, 2'd0);
      check("t4_b2b_valid", 32'(vic_valid), 32'd1);
      check("t4_b2b_way", 32'(vic_way), 32'd0);

`ifdef L2_PLRU_LOCK_EN
      // T5: locking on set 8 (reset tree, root=0)
      lkp4(4'd8, 4'hF, 4'b0011, 1'b0, 4'd0, 2'd0);
      check("t5_lock0011_way", 32'(vic_way), 32'd2);
      check("t5_lock0011_fail", 32'(vic_fail), 32'd0);
      upd4(4'd8, 2'd2);
      lkp4(4'd8, 4'hF, 4'b0011, 1'b0, 4'd0, 2'd0);
      check("t5_lock0011_node2", 32'(vic_way), 32'd3);
      lkp4(4'd8, 4'hF, 4'hF, 1'b0, 4'd0, 2'd0);
      check("t5_all_locked_fail", 32'(vic_fail), 32'd1);
      check("t5_all_locked_way", 32'(vic_way), 32'd0);
      lkp4(4'd9, 4'b1110, 4'b0001, 1'b0, 4'd0, 2'd0);
      check("t5_locked_invalid", 32'(vic_way), 32'd1);
      check("t5_locked_invalid_fail", 32'(vic_fail), 32'd0);
`endif

      // T6: reset lands between a lookup request and its edge
      upd4(4'd3, 2'd0);
      @(negedge clk);
      lkp_valid = 1'b1;
      lkp_set   = 4'd3;
      lkp_vmask = 4'hF;
      #2;
      rstn = 1'b0;
      @(posedge clk);
      #1;
      check("t6_dropped", 32'(vic_valid), 32'd0);
      lkp_valid = 1'b0;
      @(negedge clk);
      rstn = 1'b1;
      for (int s = 0; s < 16; s++) begin
         lkp4(4'(s), 4'hF, 4'h0, 1'b0, 4'd0, 2'd0);
         check($sformatf("t6_set%0d_way", s), 32'(vic_way), 32'd0);
      end

      // 8-way: ways 0..6 in order; way 6 turns the root left and the left half walks to way 0
      lkp8(6'd40, 8'hFF);
      check("w8_reset_way", 32'(v8_way), 32'd0);
      for (int w = 0; w < 7; w++) upd8(6'd40, 3'(w));
      lkp8(6'd40, 8'hFF);
      check("w8_after_0to6", 32'(v8_way), 32'd0);
      upd8(6'd40, 3'd0);
      lkp8(6'd40, 8'hFF);
      check("w8_after_w0", 32'(v8_way), 32'd4);
      lkp8(6'd40, 8'h7F);
      check("w8_invalid7", 32'(v8_way), 32'd7);
      check("w8_fail", 32'(v8_fail), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
